// File: rtl/counter_axon_addr_outputdata.sv
// Write-side address generator for the transpose-convolution output buffer.
// Accepted words are written to consecutive addresses start_val..end_val one cycle after accept.
module counter_axon_addr_outputdata #(
    parameter int ADDRESS_LENGTH = 13,
    parameter int DATA_WIDTH     = 16,
    parameter int GROUP_SIZE     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDRESS_LENGTH-1:0] start_val,
    input  logic [ADDRESS_LENGTH-1:0] end_val,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [ADDRESS_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      flag_1per16,
    output logic                      flag_last,
    output logic                      busy,
    output logic                      done,
    output logic [ADDRESS_LENGTH:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDRESS_LENGTH-1:0] GROUP_MASK = ADDRESS_LENGTH'(GROUP_SIZE - 1);

    state_t                    state_r;
    logic [ADDRESS_LENGTH-1:0] ptr_r;
    logic [ADDRESS_LENGTH-1:0] start_reg_r;
    logic [ADDRESS_LENGTH-1:0] end_reg_r;

    // Offset within the window is taken modulo 2^ADDRESS_LENGTH before masking.
    function automatic logic group_end(input logic [ADDRESS_LENGTH-1:0] p,
                                       input logic [ADDRESS_LENGTH-1:0] s);
        logic [ADDRESS_LENGTH-1:0] off;
        off = p - s;
        return (off & GROUP_MASK) == GROUP_MASK;
    endfunction

    assign in_ready = (state_r == RUN);

    // Transfer FSM with registered write port, flags and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            ptr_r         <= '0;
            start_reg_r   <= '0;
            end_reg_r     <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            flag_1per16   <= 1'b0;
            flag_last     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we      <= 1'b0;
            flag_1per16 <= 1'b0;
            flag_last   <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        words_written <= '0;
                        if (end_val >= start_val) begin
                            start_reg_r <= start_val;
                            end_reg_r   <= end_val;
                            ptr_r       <= start_val;
                            state_r     <= RUN;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        mem_we        <= 1'b1;
                        mem_addr      <= ptr_r;
                        mem_wdata     <= in_data;
                        words_written <= words_written + (ADDRESS_LENGTH + 1)'(1);
                        flag_1per16   <= group_end(ptr_r, start_reg_r);
                        // The last address ends the run without incrementing, so ptr never wraps.
                        if (ptr_r == end_reg_r) begin
                            flag_last <= 1'b1;
                            state_r   <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + ADDRESS_LENGTH'(1);
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
